// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//   mul_state_t : FSM state encoding (IDLE, BUSY, DONE)
//   MUL_WIDTH   : default operand/result width
//   MUL_CNT_W   : default iteration counter width (2**MUL_CNT_W > MUL_WIDTH)
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

endpackage

// File: rtl/add64.sv
// Ripple-free behavioural adder shared with the ALU datapath.
// Ports:
//   a, b : addends (WIDTH bits)
//   sum  : a + b, modulo 2**WIDTH. The carry-out is dropped because the
//          multiplier only keeps the low WIDTH bits of the product.
module add64
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_iter64.sv
// Iterative radix-2 shift-and-add multiplier for the EX stage. Produces the
// low WIDTH bits of a*b after WIDTH iterations and stalls the front end
// while a multiply is in flight.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, flush      : request a multiply / squash the one in flight
//   a, b              : multiplicand, multiplier (sampled on accepted start)
//   busy              : multiply in progress (state BUSY)
//   done              : one-cycle pulse, result valid (state DONE)
//   stall             : combinational hold for IF/ID/EX registers
//   result            : low WIDTH bits of the product, held until next result
//   zero, negative    : flags registered together with result
//
// Handshake: a request is taken on a rising edge where the block is IDLE,
// start=1 and flush=0; there is no ready output, the requester learns of
// acceptance through stall/busy. done is a single-cycle pulse that is never
// back-pressured; the consumer must capture result (or use the held value).
module mul_iter64
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative
);

  mul_state_t       state_q,    state_d;
  logic [WIDTH-1:0] mcand_q,    mcand_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             zero_q,     zero_d;
  logic             negative_q, negative_d;

  logic [WIDTH-1:0] acc_sum;

  add64 #(.WIDTH(WIDTH)) u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (acc_sum)
  );

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (flush) begin
          // Squash: the partial product is abandoned, outputs keep the
          // last committed result.
          state_d = IDLE;
        end else begin
          acc_d    = mplier_q[0] ? acc_sum : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Last iteration: commit the final accumulator value directly.
            state_d    = DONE;
            result_d   = acc_d;
            zero_d     = (acc_d == '0);
            negative_d = acc_d[WIDTH-1];
          end
        end
      end

      DONE: begin
        // Flush and start are both ignored here; the result is committed.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign done     = (state_q == DONE);
  // Zero in DONE so the pipeline advances and captures result this cycle.
  assign stall    = ((state_q == IDLE) && start && !flush) ||
                    ((state_q == BUSY) && !flush);
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_mul_iter64.sv
// Self-checking bench for mul_iter64: directed cases plus random operands,
// a scoreboard of expected products and a monitor that compares each done.
module tb_mul_iter64;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] result;
  logic         zero;
  logic         negative;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mul_iter64 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .result   (result),
    .zero     (zero),
    .negative (negative)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  t_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_exp = '0;
  bit           hold_chk = 1'b0;
  bit           have_prev = 1'b0;
  int unsigned  prev_done = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the product of two unsigned WIDTH-bit numbers, truncated.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return full[W-1:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      check("stall", {63'd0, stall},
            {63'd0, (busy && !flush) || (!busy && !done && start && !flush)});
      if (done === 1'b1) begin
        check("done_not_busy", {63'd0, busy}, 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          logic [W-1:0] e;
          int unsigned  t;
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("result",   result,             e);
          check("zero",     {63'd0, zero},      {63'd0, e == '0});
          check("negative", {63'd0, negative},  {63'd0, e[W-1]});
          check("latency",  64'(cyc - t),       64'd64);
          if (hold_chk && have_prev)
            check("done_gap", 64'(cyc - prev_done), 64'd66);
        end
        have_prev = 1'b1;
        prev_done = cyc;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got busy=%0b expected idle within 300 cycles", busy);
    end
  endtask

  // Issue one accepted request; returns at #1 after the accepting edge.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit expect_done);
    wait_idle();
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    if (expect_done) begin
      exp_q.push_back(ref_mul(x, y));
      t_q.push_back(cyc);
      last_exp = ref_mul(x, y);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy",   {63'd0, busy},     64'd0);
    check("rst_done",   {63'd0, done},     64'd0);
    check("rst_stall",  {63'd0, stall},    64'd0);
    check("rst_result", result,            64'd0);
    check("rst_zero",   {63'd0, zero},     64'd1);
    check("rst_neg",    {63'd0, negative}, 64'd0);
    @(posedge clk); #1;

    // Basic products, sign pattern and wrap to zero.
    do_mul(64'd3, 64'd5, 1'b1);
    @(negedge clk);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    do_mul(-64'sd2418, 64'd10, 1'b1);
    do_mul(64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
    wait_idle();
    check("neg_constant", ref_mul(-64'sd2418, 64'd10), 64'hFFFF_FFFF_FFFF_A18C);

    // Flush at iteration 20: no done, result unchanged.
    do_mul(64'd7, 64'd9, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   {63'd0, busy}, 64'd0);
    check("flush_result", result,        last_exp);
    @(posedge clk); #1;
    do_mul(64'd2, 64'd2, 1'b1);

    // Reset at iteration 40: reset values, no done.
    do_mul(64'd7, 64'd9, 1'b0);
    repeat (39) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",   {63'd0, busy},     64'd0);
    check("midrst_done",   {63'd0, done},     64'd0);
    check("midrst_result", result,            64'd0);
    check("midrst_zero",   {63'd0, zero},     64'd1);
    check("midrst_neg",    {63'd0, negative}, 64'd0);
    last_exp = '0;
    repeat (70) @(posedge clk);
    #1;

    // Flush asserted exactly in the DONE cycle is ignored.
    do_mul(64'd123456789, 64'd987654321, 1'b1);
    repeat (64) @(posedge clk);
    #1;
    check("done_cycle", {63'd0, done}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    // Held start with changing operands: only every 66th cycle is accepted.
    wait_idle();
    hold_chk  = 1'b1;
    have_prev = 1'b0;
    for (int k = 0; k < 198; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      start = 1'b1;
      if (k % 66 == 0) begin
        exp_q.push_back(ref_mul(a, b));
        t_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();
    hold_chk = 1'b0;

    // Random operands, including corner values.
    do_mul({W{1'b1}}, {W{1'b1}}, 1'b1);
    do_mul({W{1'b1}}, 64'd0, 1'b1);
    do_mul(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = {$urandom, $urandom};
      y = (i % 2 == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 1000));
      do_mul(x, y, 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end

    // Drain the scoreboard, bounded.
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        @(posedge clk);
        n++;
      end
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
